// File: rtl/flappy_pkg.sv
// Shared geometry, coordinate type and FSM encoding for the pipe/coin field
// and the blocks that consume it.
package flappy_pkg;

  // The display selector is wired for exactly five slots of 10-bit fields.
  localparam int N_SLOTS = 5;
  localparam int COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [1:0]         state_t;

  // Screen bounds of the playfield.
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Default field geometry.
  localparam int DEF_PIPE_W    = 40;
  localparam int DEF_SPACING   = 100;
  localparam int DEF_X_START   = 160;
  localparam int DEF_SPEED     = 2;
  localparam int DEF_GAP_H     = 120;
  localparam int DEF_INIT_TOP  = 180;
  localparam int DEF_GAP_MIN   = 40;
  localparam int DEF_GAP_RANGE = 200;
  localparam int DEF_COIN_W    = 20;
  localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;

  // Scroller FSM encoding.
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_RUN    = 2'd1;
  localparam state_t ST_FREEZE = 2'd2;

  // Fold an 8-bit random byte into [gmin, gmin+grange-1]; grange is 128..255,
  // so a single conditional subtraction is enough.
  function automatic coord_t gap_top(input logic [7:0] r, input int gmin,
                                     input int grange);
    logic [7:0] rf;
    rf = (r >= 8'(grange)) ? r - 8'(grange) : r;
    return coord_t'(gmin) + coord_t'(rf);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting right every clock.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic        fb;

  assign fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign q  = lfsr_q;

  // Free-running shift; reset reloads the seed so sequences repeat per game.
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= {fb, lfsr_q[15:1]};
  end

endmodule

// File: rtl/pipe_scroller.sv
// Scrolling pipe/coin field: five slots drift left on each frame tick and
// respawn behind the last pipe with a random gap when they leave the screen.
module pipe_scroller
  import flappy_pkg::*;
#(
  parameter int          PIPE_W    = DEF_PIPE_W,
  parameter int          SPACING   = DEF_SPACING,
  parameter int          X_START   = DEF_X_START,
  parameter int          SPEED     = DEF_SPEED,
  parameter int          GAP_H     = DEF_GAP_H,
  parameter int          INIT_TOP  = DEF_INIT_TOP,
  parameter int          GAP_MIN   = DEF_GAP_MIN,
  parameter int          GAP_RANGE = DEF_GAP_RANGE,
  parameter int          COIN_W    = DEF_COIN_W,
  parameter logic [15:0] LFSR_SEED = DEF_LFSR_SEED
) (
  input  logic        clk_100MHz,
  input  logic        q_Initial,
  input  logic        tick,
  input  logic        start,
  input  logic        game_over,
  output logic [49:0] X_Edge_L,
  output logic [49:0] X_Edge_R,
  output logic [49:0] Y_Edge_Top,
  output logic [49:0] Y_Edge_Bottom,
  output logic [49:0] X_Coin_L,
  output logic [49:0] X_Coin_R,
  output logic [49:0] Y_Coin,
  output logic        shift_Coin,
  output logic        running
);

  // Offsets from a slot's left edge / gap top to each derived coordinate.
  localparam coord_t R_OFF    = coord_t'(PIPE_W - 1);
  localparam coord_t CL_OFF   = coord_t'(PIPE_W + (SPACING - PIPE_W - COIN_W) / 2);
  localparam coord_t CR_OFF   = coord_t'(PIPE_W + (SPACING - PIPE_W - COIN_W) / 2 + COIN_W - 1);
  localparam coord_t BOT_OFF  = coord_t'(GAP_H);
  localparam coord_t CY_OFF   = coord_t'((GAP_H - COIN_W) / 2);
  localparam coord_t SPD      = coord_t'(SPEED);
  // A wrapping slot jumps one full field length behind, minus this tick's step.
  localparam coord_t WRAP_ADD = coord_t'(N_SLOTS * SPACING - SPEED);
  localparam coord_t TOP_INIT = coord_t'(INIT_TOP);

  state_t              state_q, state_d;
  logic                running_q, shift_q;
  logic                move;
  logic [N_SLOTS-1:0]  wrap_vec;
  logic [15:0]         lfsr_q;
  coord_t              new_top;
  logic                unused_lfsr_hi;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk (clk_100MHz),
    .rst (q_Initial),
    .q   (lfsr_q)
  );

  // Only the low byte feeds gap placement.
  assign unused_lfsr_hi = ^lfsr_q[15:8];
  assign new_top        = gap_top(lfsr_q[7:0], GAP_MIN, GAP_RANGE);

  // game_over outranks tick, so a freezing cycle never moves the field.
  assign move = (state_q == ST_RUN) && tick && !game_over;

  // Next FSM state: start only counts in IDLE, FREEZE is left only by reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_RUN;
      ST_RUN:    if (game_over) state_d = ST_FREEZE;
      ST_FREEZE: state_d = ST_FREEZE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Control registers; shift_Coin lines up with the first cycle of new outputs.
  always_ff @(posedge clk_100MHz) begin
    if (q_Initial) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      shift_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == ST_RUN);
      shift_q   <= |wrap_vec;
    end
  end

  assign running    = running_q;
  assign shift_Coin = shift_q;

  for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
    localparam coord_t X_INIT = coord_t'(X_START + i * SPACING);

    coord_t xl_q, top_q, xl_d, top_d;
    coord_t r_q, bot_q, cl_q, cr_q, cy_q;
    logic   wrap;

    // Slot step: shift left, or respawn behind the last pipe with a new gap.
    always_comb begin
      xl_d  = xl_q;
      top_d = top_q;
      wrap  = 1'b0;
      if (move) begin
        if (xl_q >= SPD) begin
          xl_d = xl_q - SPD;
        end else begin
          xl_d  = xl_q + WRAP_ADD;
          top_d = new_top;
          wrap  = 1'b1;
        end
      end
    end

    // Slot state plus derived edges, all registered from the same next state.
    always_ff @(posedge clk_100MHz) begin
      if (q_Initial) begin
        xl_q  <= X_INIT;
        top_q <= TOP_INIT;
        r_q   <= X_INIT + R_OFF;
        bot_q <= TOP_INIT + BOT_OFF;
        cl_q  <= X_INIT + CL_OFF;
        cr_q  <= X_INIT + CR_OFF;
        cy_q  <= TOP_INIT + CY_OFF;
      end else begin
        xl_q  <= xl_d;
        top_q <= top_d;
        r_q   <= xl_d + R_OFF;
        bot_q <= top_d + BOT_OFF;
        cl_q  <= xl_d + CL_OFF;
        cr_q  <= xl_d + CR_OFF;
        cy_q  <= top_d + CY_OFF;
      end
    end

    assign wrap_vec[i] = wrap;

    assign X_Edge_L[10*i +: 10]      = xl_q;
    assign X_Edge_R[10*i +: 10]      = r_q;
    assign Y_Edge_Top[10*i +: 10]    = top_q;
    assign Y_Edge_Bottom[10*i +: 10] = bot_q;
    assign X_Coin_L[10*i +: 10]      = cl_q;
    assign X_Coin_R[10*i +: 10]      = cr_q;
    assign Y_Coin[10*i +: 10]        = cy_q;
  end

endmodule

// File: tb/tb_pipe_scroller.sv
// Directed bench for pipe_scroller: vector table plus hand-written wrap,
// freeze, reset-collision and long random-run sequences.
module tb_pipe_scroller;

  logic        clk_100MHz = 1'b0;
  logic        q_Initial  = 1'b0;
  logic        tick       = 1'b0;
  logic        start      = 1'b0;
  logic        game_over  = 1'b0;
  logic [49:0] X_Edge_L, X_Edge_R, Y_Edge_Top, Y_Edge_Bottom;
  logic [49:0] X_Coin_L, X_Coin_R, Y_Coin;
  logic        shift_Coin, running;

  always #5 clk_100MHz = ~clk_100MHz;

  pipe_scroller dut (
    .clk_100MHz    (clk_100MHz),
    .q_Initial     (q_Initial),
    .tick          (tick),
    .start         (start),
    .game_over     (game_over),
    .X_Edge_L      (X_Edge_L),
    .X_Edge_R      (X_Edge_R),
    .Y_Edge_Top    (Y_Edge_Top),
    .Y_Edge_Bottom (Y_Edge_Bottom),
    .X_Coin_L      (X_Coin_L),
    .X_Coin_R      (X_Coin_R),
    .Y_Coin        (Y_Coin),
    .shift_Coin    (shift_Coin),
    .running       (running)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  int          m_xl[5];
  int          m_top[5];
  logic [15:0] m_lfsr;
  int          m_state = 0;
  int          m_run   = 0;
  int          m_sh    = 0;

  typedef struct {
    int st; int tk; int go; int rs;
    int l0; int l4; int run; int sh;
  } vec_t;

  vec_t vt[12];

  function automatic int fld(input logic [49:0] bus, input int i);
    return int'(bus[10*i +: 10]);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // One clock: apply inputs, step the model alongside the DUT, sample at +1.
  task automatic cyc(input int st, input int tk, input int go, input int rs);
    logic fb;
    int   r;
    start = st[0]; tick = tk[0]; game_over = go[0]; q_Initial = rs[0];
    @(posedge clk_100MHz);
    m_sh = 0;
    if (rs != 0) begin
      for (int i = 0; i < 5; i++) begin
        m_xl[i]  = 160 + 100 * i;
        m_top[i] = 180;
      end
      m_lfsr  = 16'hACE1;
      m_state = 0;
      m_run   = 0;
    end else begin
      if (m_state == 1 && tk != 0 && go == 0) begin
        for (int i = 0; i < 5; i++) begin
          if (m_xl[i] >= 2) begin
            m_xl[i] = m_xl[i] - 2;
          end else begin
            m_xl[i]  = m_xl[i] + 498;
            r        = int'(m_lfsr[7:0]);
            m_top[i] = 40 + ((r >= 200) ? r - 200 : r);
            m_sh     = 1;
          end
        end
      end
      if (m_state == 0 && st != 0)      m_state = 1;
      else if (m_state == 1 && go != 0) m_state = 2;
      m_run  = (m_state == 1) ? 1 : 0;
      fb     = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
      m_lfsr = {fb, m_lfsr[15:1]};
    end
    #1;
    start = 1'b0; tick = 1'b0; game_over = 1'b0; q_Initial = 1'b0;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("%s L[%0d]", tag, i),   fld(X_Edge_L, i),      m_xl[i]);
      chk($sformatf("%s R[%0d]", tag, i),   fld(X_Edge_R, i),      m_xl[i] + 39);
      chk($sformatf("%s Top[%0d]", tag, i), fld(Y_Edge_Top, i),    m_top[i]);
      chk($sformatf("%s Bot[%0d]", tag, i), fld(Y_Edge_Bottom, i), m_top[i] + 120);
      chk($sformatf("%s CL[%0d]", tag, i),  fld(X_Coin_L, i),      m_xl[i] + 60);
      chk($sformatf("%s CR[%0d]", tag, i),  fld(X_Coin_R, i),      m_xl[i] + 79);
      chk($sformatf("%s CY[%0d]", tag, i),  fld(Y_Coin, i),        m_top[i] + 50);
    end
    chk({tag, " running"}, int'(running), m_run);
    chk({tag, " shift"},   int'(shift_Coin), m_sh);
  endtask

  function automatic int pending_wrap();
    for (int i = 0; i < 5; i++) if (m_xl[i] < 2) return 1;
    return 0;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    int wraps;
    int cycles;
    int top_v;
    int tk;

    // Reset layout after two reset cycles.
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("rst L0",   fld(X_Edge_L, 0), 160);
    chk("rst L1",   fld(X_Edge_L, 1), 260);
    chk("rst L2",   fld(X_Edge_L, 2), 360);
    chk("rst L3",   fld(X_Edge_L, 3), 460);
    chk("rst L4",   fld(X_Edge_L, 4), 560);
    chk("rst R0",   fld(X_Edge_R, 0), 199);
    chk("rst Top0", fld(Y_Edge_Top, 0), 180);
    chk("rst Bot0", fld(Y_Edge_Bottom, 0), 300);
    chk("rst CY0",  fld(Y_Coin, 0), 230);
    chk("rst CL0",  fld(X_Coin_L, 0), 220);
    chk("rst run",  int'(running), 0);
    chk("rst shift", int'(shift_Coin), 0);
    check_all("rst");

    // st tk go rs | L0 L4 run shift
    vt[0]  = '{0, 0, 0, 1, 160, 560, 0, 0};
    vt[1]  = '{0, 0, 0, 0, 160, 560, 0, 0};
    vt[2]  = '{0, 1, 0, 0, 160, 560, 0, 0};  // tick in IDLE ignored
    vt[3]  = '{1, 1, 0, 0, 160, 560, 1, 0};  // start wins, tick not applied
    vt[4]  = '{0, 1, 0, 0, 158, 558, 1, 0};
    vt[5]  = '{0, 0, 0, 0, 158, 558, 1, 0};
    vt[6]  = '{0, 1, 0, 0, 156, 556, 1, 0};
    vt[7]  = '{0, 1, 1, 0, 156, 556, 0, 0};  // game_over beats tick
    vt[8]  = '{0, 1, 0, 0, 156, 556, 0, 0};  // frozen
    vt[9]  = '{1, 1, 0, 0, 156, 556, 0, 0};  // start ignored in FREEZE
    vt[10] = '{0, 0, 0, 1, 160, 560, 0, 0};
    vt[11] = '{1, 0, 0, 0, 160, 560, 1, 0};

    for (int k = 0; k < 12; k++) begin
      cyc(vt[k].st, vt[k].tk, vt[k].go, vt[k].rs);
      chk($sformatf("vec%0d L0", k),    fld(X_Edge_L, 0), vt[k].l0);
      chk($sformatf("vec%0d L4", k),    fld(X_Edge_L, 4), vt[k].l4);
      chk($sformatf("vec%0d run", k),   int'(running),    vt[k].run);
      chk($sformatf("vec%0d shift", k), int'(shift_Coin), vt[k].sh);
      check_all($sformatf("vec%0d", k));
    end

    // No tick: positions hold.
    for (int k = 0; k < 10; k++) cyc(0, 0, 0, 0);
    chk("hold L0", fld(X_Edge_L, 0), 160);
    chk("hold L4", fld(X_Edge_L, 4), 560);

    // Wrap of slot 0 on tick 81.
    for (int k = 0; k < 80; k++) cyc(0, 1, 0, 0);
    chk("pre-wrap L0", fld(X_Edge_L, 0), 0);
    chk("pre-wrap shift", int'(shift_Coin), 0);
    cyc(0, 1, 0, 0);
    chk("wrap L0", fld(X_Edge_L, 0), 498);
    chk("wrap L4", fld(X_Edge_L, 4), 398);
    chk("wrap shift", int'(shift_Coin), 1);
    top_v = fld(Y_Edge_Top, 0);
    chk("wrap top range", int'(top_v >= 40 && top_v <= 239), 1);
    chk("wrap bottom", fld(Y_Edge_Bottom, 0), top_v + 120);
    check_all("wrap");
    cyc(0, 0, 0, 0);
    chk("wrap shift drop", int'(shift_Coin), 0);

    // Reset collides with a wrapping tick.
    guard = 0;
    while (pending_wrap() == 0 && guard < 200) begin
      cyc(0, 1, 0, 0);
      guard++;
    end
    chk("collide reach", int'(guard < 200), 1);
    cyc(0, 1, 0, 1);
    chk("collide L0", fld(X_Edge_L, 0), 160);
    chk("collide L1", fld(X_Edge_L, 1), 260);
    chk("collide Top1", fld(Y_Edge_Top, 1), 180);
    chk("collide shift", int'(shift_Coin), 0);
    chk("collide run", int'(running), 0);
    check_all("collide");
    // First gap after reset must come from the reseeded LFSR.
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 81; k++) cyc(0, 1, 0, 0);
    chk("reseed shift", int'(shift_Coin), 1);
    check_all("reseed");

    // Long run with irregular ticks, checked at every respawn.
    wraps  = 0;
    cycles = 0;
    while (wraps < 300 && cycles < 20000) begin
      tk = ($urandom_range(0, 7) != 0) ? 1 : 0;
      cyc(0, tk, 0, 0);
      cycles++;
      chk("rnd shift", int'(shift_Coin), m_sh);
      if (m_sh != 0) begin
        wraps++;
        check_all("rnd");
        for (int i = 0; i < 5; i++) begin
          top_v = fld(Y_Edge_Top, i);
          chk($sformatf("rnd range[%0d]", i), int'(top_v >= 40 && top_v <= 239), 1);
          chk($sformatf("rnd adj[%0d]", i),
              (((fld(X_Edge_L, (i + 1) % 5) - fld(X_Edge_L, i)) % 500) + 500) % 500, 100);
        end
      end
    end
    chk("rnd wraps", wraps, 300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
